gctr_ctrl: RTL

Sequencer for the GCTR stage of the AES-GCM datapath. Loads an initial counter block, issues successive counter blocks to the AES block cipher over a valid/ready handshake, XORs each returned keystream block with one input data block, and emits the result. The counter is incremented by the standard S-bit inc function, and the final partial block is truncated. Sits between the GCM top-level control and the AES core; its output feeds the GHASH stage.

---
 rtl/gcm_pkg.sv | 15 +
 rtl/gctr_inc_s.sv | 20 ++
 rtl/gctr_ctrl.sv | 122 ++++++++++++
 3 files changed

// File: rtl/gcm_pkg.sv
// gcm_pkg: shared GCM definitions - block width, GCTR FSM states, final-block byte mask
package gcm_pkg;

    localparam int BLOCK_WIDTH = 128;

    typedef enum logic [2:0] {IDLE, REQ, KS_WAIT, XOR, OUT, DONE} gctr_state_e;

    // Keeps the top last_bytes*8 bits; 0 or anything past a full block means a full block.
    function automatic logic [BLOCK_WIDTH-1:0] byte_mask(input logic [4:0] last_bytes);
        int nbits;
        nbits = (last_bytes == 5'd0 || int'(last_bytes) * 8 > BLOCK_WIDTH) ? BLOCK_WIDTH : int'(last_bytes) * 8;
        return ~({BLOCK_WIDTH{1'b1}} >> nbits);
    endfunction

endpackage

// File: rtl/gctr_inc_s.sv
// gctr_inc_s: combinational inc_S - increments the low S bits modulo 2^S, upper bits untouched
//   ctr_i  counter block in
//   ctr_o  counter block with low S bits incremented (unchanged if S is 0 or wider than the block)
module gctr_inc_s #(
    parameter int BLOCK_WIDTH = 128,
    parameter int S           = 32
) (
    input  logic [BLOCK_WIDTH-1:0] ctr_i,
    output logic [BLOCK_WIDTH-1:0] ctr_o
);

    if (S <= 0 || S > BLOCK_WIDTH) begin : g_pass
        assign ctr_o = ctr_i;
    end else if (S == BLOCK_WIDTH) begin : g_full
        assign ctr_o = ctr_i + BLOCK_WIDTH'(1);
    end else begin : g_part
        assign ctr_o = {ctr_i[BLOCK_WIDTH-1:S], ctr_i[S-1:0] + S'(1)};
    end

endmodule

// File: rtl/gctr_ctrl.sv
// gctr_ctrl: AES-GCM GCTR sequencer - issues counter blocks to AES, XORs keystream with data
//   start/icb/num_blocks/last_bytes  message setup, latched on start in IDLE
//   aes_req_*                        counter block to AES (valid/ready)
//   aes_resp_*                       keystream from AES (single-cycle valid, no backpressure)
//   din_*                            input data block (valid/ready)
//   dout_*                           XOR result, final block truncated (valid/ready)
//   busy/done                        busy outside IDLE; done pulses once per message
module gctr_ctrl
    import gcm_pkg::*;
#(
    parameter int BLOCK_WIDTH = gcm_pkg::BLOCK_WIDTH,
    parameter int S           = 32,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [BLOCK_WIDTH-1:0] icb,
    input  logic [CNT_WIDTH-1:0]   num_blocks,
    input  logic [4:0]             last_bytes,
    output logic                   aes_req_valid,
    input  logic                   aes_req_ready,
    output logic [BLOCK_WIDTH-1:0] aes_req_data,
    input  logic                   aes_resp_valid,
    input  logic [BLOCK_WIDTH-1:0] aes_resp_data,
    input  logic                   din_valid,
    output logic                   din_ready,
    input  logic [BLOCK_WIDTH-1:0] din,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic [BLOCK_WIDTH-1:0] dout,
    output logic                   busy,
    output logic                   done
);

    gctr_state_e            state_q, state_d;
    logic [BLOCK_WIDTH-1:0] ctr_q, ctr_d, ctr_inc;
    logic [BLOCK_WIDTH-1:0] ks_q, ks_d;
    logic [BLOCK_WIDTH-1:0] dout_q, dout_d;
    logic [BLOCK_WIDTH-1:0] mask;
    logic [CNT_WIDTH-1:0]   rem_q, rem_d;
    logic [4:0]             lb_q, lb_d;
    logic                   last;

    gctr_inc_s #(.BLOCK_WIDTH(BLOCK_WIDTH), .S(S)) u_inc (
        .ctr_i (ctr_q),
        .ctr_o (ctr_inc)
    );

    assign last = rem_q == CNT_WIDTH'(1);
    assign mask = last ? byte_mask(lb_q) : '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ctr_q   <= '0;
            ks_q    <= '0;
            dout_q  <= '0;
            rem_q   <= '0;
            lb_q    <= '0;
        end else begin
            state_q <= state_d;
            ctr_q   <= ctr_d;
            ks_q    <= ks_d;
            dout_q  <= dout_d;
            rem_q   <= rem_d;
            lb_q    <= lb_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        ks_d    = ks_q;
        dout_d  = dout_q;
        rem_d   = rem_q;
        lb_d    = lb_q;
        case (state_q)
            IDLE: if (start) begin
                lb_d = last_bytes;
                if (num_blocks == '0) begin
                    state_d = DONE;
                end else begin
                    ctr_d   = icb;
                    rem_d   = num_blocks;
                    state_d = REQ;
                end
            end
            REQ:     if (aes_req_ready) state_d = KS_WAIT;
            KS_WAIT: if (aes_resp_valid) begin
                ks_d    = aes_resp_data;
                state_d = XOR;
            end
            XOR: if (din_valid) begin
                dout_d  = (din ^ ks_q) & mask;
                state_d = OUT;
            end
            OUT: if (dout_ready) begin
                if (last) begin
                    state_d = DONE;
                end else begin
                    ctr_d   = ctr_inc;
                    rem_d   = rem_q - CNT_WIDTH'(1);
                    state_d = REQ;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        aes_req_valid = state_q == REQ;
        din_ready     = state_q == XOR;
        dout_valid    = state_q == OUT;
        busy          = state_q != IDLE;
        done          = state_q == DONE;
        aes_req_data  = ctr_q;
        dout          = dout_q;
    end

endmodule
